// File: rtl/sram_bus_arbiter_pkg.sv
// Shared encodings for the SRAM bus arbiter: owner tags, transfer sizes and grant states.
package sram_bus_arbiter_pkg;

    typedef logic       owner_t;
    typedef logic [1:0] size_t;

    localparam owner_t OWN_INST = 1'b0;
    localparam owner_t OWN_DATA = 1'b1;

    localparam size_t SZ_BYTE = 2'd0;
    localparam size_t SZ_HALF = 2'd1;
    localparam size_t SZ_WORD = 2'd2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GNT_D = 2'd1;
    localparam logic [1:0] ST_GNT_I = 2'd2;

endpackage

// File: rtl/sram_bus_arbiter_if.sv
// Split-transaction SRAM-like bus: req/addr_ok request phase, data_ok response phase.
interface sram_bus_arbiter_if
    import sram_bus_arbiter_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic            req;
    logic            wr;
    size_t           size;
    logic [AW-1:0]   addr;
    logic [DW/8-1:0] wstrb;
    logic [DW-1:0]   wdata;
    logic            addr_ok;
    logic            data_ok;
    logic [DW-1:0]   rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/sram_bus_arbiter_owner_fifo.sv
// 1-bit-wide FIFO recording which master owns each outstanding memory transaction.
module sram_bus_arbiter_owner_fifo
    import sram_bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_OUT = 2,
    localparam int unsigned PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1,
    localparam int unsigned CW = $clog2(MAX_OUT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  owner_t        push_owner,
    input  logic          pop,
    output owner_t        head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [MAX_OUT-1:0] mem_q, mem_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               do_push, do_pop;

    assign full    = (count_q == CW'(MAX_OUT));
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty;
    // A push at full is only safe when the head slot is freed in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_owner;
            wr_ptr_d = (wr_ptr_q == PW'(MAX_OUT - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(MAX_OUT - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM port between IF and MEM requesters; data has fixed priority and
// responses are steered back by an in-order owner FIFO.
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_OUT = 2,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32
) (
    input  logic               clk,
    input  logic               reset,
    sram_bus_arbiter_if.slave  inst_bus,
    sram_bus_arbiter_if.slave  data_bus,
    sram_bus_arbiter_if.master mem_bus
);

    localparam int unsigned CW = $clog2(MAX_OUT + 1);

    logic [1:0]      state_q, state_d;
    logic            grant_d, grant_i;
    logic            accept, pop;
    owner_t          push_owner, fifo_head;
    logic            fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count;

    logic            sel_wr;
    size_t           sel_size;
    logic [AW-1:0]   sel_addr;
    logic [DW/8-1:0] sel_wstrb;
    logic [DW-1:0]   sel_wdata;

    // Arbitration only happens from IDLE, so every acceptance is followed by a bubble
    // and the full check uses the registered count, never the same-cycle pop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_full) begin
                    if (data_bus.req) begin
                        state_d = ST_GNT_D;
                    end else if (inst_bus.req) begin
                        state_d = ST_GNT_I;
                    end
                end
            end
            ST_GNT_D, ST_GNT_I: begin
                if (mem_bus.addr_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        grant_d = !reset && (state_q == ST_GNT_D);
        grant_i = !reset && (state_q == ST_GNT_I);
    end

    always_comb begin
        if (grant_i) begin
            sel_wr    = inst_bus.wr;
            sel_size  = inst_bus.size;
            sel_addr  = inst_bus.addr;
            sel_wstrb = inst_bus.wstrb;
            sel_wdata = inst_bus.wdata;
        end else begin
            sel_wr    = data_bus.wr;
            sel_size  = data_bus.size;
            sel_addr  = data_bus.addr;
            sel_wstrb = data_bus.wstrb;
            sel_wdata = data_bus.wdata;
        end
    end

    assign mem_bus.req   = grant_d | grant_i;
    assign mem_bus.wr    = sel_wr;
    assign mem_bus.size  = sel_size;
    assign mem_bus.addr  = sel_addr;
    assign mem_bus.wstrb = sel_wstrb;
    assign mem_bus.wdata = sel_wdata;

    assign accept           = mem_bus.req & mem_bus.addr_ok;
    assign data_bus.addr_ok = grant_d & mem_bus.addr_ok;
    assign inst_bus.addr_ok = grant_i & mem_bus.addr_ok;
    assign push_owner       = grant_d ? OWN_DATA : OWN_INST;

    // Responses with nothing outstanding (e.g. stale ones after a reset) are dropped.
    assign pop              = !reset && mem_bus.data_ok && !fifo_empty;
    assign data_bus.data_ok = pop && (fifo_head == OWN_DATA);
    assign inst_bus.data_ok = pop && (fifo_head == OWN_INST);
    assign data_bus.rdata   = mem_bus.rdata;
    assign inst_bus.rdata   = mem_bus.rdata;

    sram_bus_arbiter_owner_fifo #(
        .MAX_OUT (MAX_OUT)
    ) u_owner_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (accept),
        .push_owner (push_owner),
        .pop        (pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    full_matches_count: assert property (@(posedge clk) disable iff (reset)
        fifo_full == (fifo_count == CW'(MAX_OUT)));

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter with hand-computed expectations (MAX_OUT=2).
module tb_sram_bus_arbiter;
    import sram_bus_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    sram_bus_arbiter_if #(.AW(32), .DW(32)) inst_bus ();
    sram_bus_arbiter_if #(.AW(32), .DW(32)) data_bus ();
    sram_bus_arbiter_if #(.AW(32), .DW(32)) mem_bus ();

    sram_bus_arbiter #(
        .MAX_OUT (2),
        .AW      (32),
        .DW      (32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .inst_bus (inst_bus),
        .data_bus (data_bus),
        .mem_bus  (mem_bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic inst_drive(input logic req, input logic [31:0] addr);
        inst_bus.req   = req;
        inst_bus.wr    = 1'b0;
        inst_bus.size  = SZ_WORD;
        inst_bus.addr  = addr;
        inst_bus.wstrb = 4'h0;
        inst_bus.wdata = 32'h0;
    endtask

    task automatic data_drive(input logic req, input logic wr, input size_t size,
                              input logic [31:0] addr, input logic [3:0] wstrb,
                              input logic [31:0] wdata);
        data_bus.req   = req;
        data_bus.wr    = wr;
        data_bus.size  = size;
        data_bus.addr  = addr;
        data_bus.wstrb = wstrb;
        data_bus.wdata = wdata;
    endtask

    task automatic mem_drive(input logic addr_ok, input logic data_ok, input logic [31:0] rdata);
        mem_bus.addr_ok = addr_ok;
        mem_bus.data_ok = data_ok;
        mem_bus.rdata   = rdata;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_mem_req"}, 32'(mem_bus.req), 0);
        check_eq({tag, "_inst_addr_ok"}, 32'(inst_bus.addr_ok), 0);
        check_eq({tag, "_data_addr_ok"}, 32'(data_bus.addr_ok), 0);
        check_eq({tag, "_inst_data_ok"}, 32'(inst_bus.data_ok), 0);
        check_eq({tag, "_data_data_ok"}, 32'(data_bus.data_ok), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset, with a stray response on the memory side throughout.
        reset = 1'b1;
        inst_drive(1'b0, 32'h0);
        data_drive(1'b0, 1'b0, SZ_WORD, 32'h0, 4'h0, 32'h0);
        mem_drive(1'b0, 1'b1, 32'hBAD0_0000);
        repeat (2) next_cycle();
        settle();
        check_quiet("rst");
        next_cycle();
        reset = 1'b0;
        mem_drive(1'b0, 1'b0, 32'h0);
        settle();
        check_quiet("post_rst");

        // Single data load.
        next_cycle();
        data_drive(1'b1, 1'b0, SZ_WORD, 32'h0000_1000, 4'h0, 32'h0);
        settle();
        check_eq("t1_idle_mem_req", 32'(mem_bus.req), 0);
        next_cycle();
        mem_drive(1'b1, 1'b0, 32'h0);
        settle();
        check_eq("t1_mem_req", 32'(mem_bus.req), 1);
        check_eq("t1_mem_addr", mem_bus.addr, 32'h0000_1000);
        check_eq("t1_mem_wr", 32'(mem_bus.wr), 0);
        check_eq("t1_data_addr_ok", 32'(data_bus.addr_ok), 1);
        check_eq("t1_inst_addr_ok", 32'(inst_bus.addr_ok), 0);
        next_cycle();
        data_drive(1'b0, 1'b0, SZ_WORD, 32'h0, 4'h0, 32'h0);
        mem_drive(1'b0, 1'b0, 32'h0);
        settle();
        check_quiet("t1_gap");
        next_cycle();
        mem_drive(1'b0, 1'b1, 32'hDEAD_BEEF);
        settle();
        check_eq("t1_data_data_ok", 32'(data_bus.data_ok), 1);
        check_eq("t1_data_rdata", data_bus.rdata, 32'hDEAD_BEEF);
        check_eq("t1_inst_data_ok", 32'(inst_bus.data_ok), 0);
        next_cycle();
        mem_drive(1'b0, 1'b1, 32'h0000_0BAD);
        settle();
        check_quiet("t1_empty_resp");
        next_cycle();
        mem_drive(1'b0, 1'b0, 32'h0);

        // Contention: data (a store) wins, inst follows after the bubble.
        inst_drive(1'b1, 32'h0000_2000);
        data_drive(1'b1, 1'b1, SZ_HALF, 32'h0000_3000, 4'h3, 32'h0000_CAFE);
        settle();
        check_eq("t2_idle_mem_req", 32'(mem_bus.req), 0);
        next_cycle();
        mem_drive(1'b1, 1'b0, 32'h0);
        settle();
        check_eq("t2_d_mem_addr", mem_bus.addr, 32'h0000_3000);
        check_eq("t2_d_mem_wr", 32'(mem_bus.wr), 1);
        check_eq("t2_d_mem_size", 32'(mem_bus.size), 32'(SZ_HALF));
        check_eq("t2_d_mem_wstrb", 32'(mem_bus.wstrb), 32'h3);
        check_eq("t2_d_mem_wdata", mem_bus.wdata, 32'h0000_CAFE);
        check_eq("t2_d_addr_ok", 32'(data_bus.addr_ok), 1);
        check_eq("t2_d_inst_addr_ok", 32'(inst_bus.addr_ok), 0);
        next_cycle();
        data_drive(1'b0, 1'b0, SZ_WORD, 32'h0, 4'h0, 32'h0);
        mem_drive(1'b0, 1'b0, 32'h0);
        settle();
        check_eq("t2_bubble_mem_req", 32'(mem_bus.req), 0);
        next_cycle();
        mem_drive(1'b1, 1'b0, 32'h0);
        settle();
        check_eq("t2_i_mem_req", 32'(mem_bus.req), 1);
        check_eq("t2_i_mem_addr", mem_bus.addr, 32'h0000_2000);
        check_eq("t2_i_mem_wr", 32'(mem_bus.wr), 0);
        check_eq("t2_i_addr_ok", 32'(inst_bus.addr_ok), 1);
        next_cycle();
        inst_drive(1'b0, 32'h0);
        mem_drive(1'b0, 1'b1, 32'h0000_00AA);
        settle();
        check_eq("t2_r1_data_ok", 32'(data_bus.data_ok), 1);
        check_eq("t2_r1_inst_ok", 32'(inst_bus.data_ok), 0);
        next_cycle();
        mem_drive(1'b0, 1'b1, 32'h0000_00BB);
        settle();
        check_eq("t2_r2_inst_ok", 32'(inst_bus.data_ok), 1);
        check_eq("t2_r2_inst_rdata", inst_bus.rdata, 32'h0000_00BB);
        check_eq("t2_r2_data_ok", 32'(data_bus.data_ok), 0);
        next_cycle();
        mem_drive(1'b0, 1'b0, 32'h0);

        // Outstanding limit: third fetch waits for the first response.
        inst_drive(1'b1, 32'h0000_0100);
        next_cycle();
        mem_drive(1'b1, 1'b0, 32'h0);
        settle();
        check_eq("t3_f1_addr", mem_bus.addr, 32'h0000_0100);
        check_eq("t3_f1_addr_ok", 32'(inst_bus.addr_ok), 1);
        next_cycle();
        inst_drive(1'b1, 32'h0000_0104);
        mem_drive(1'b0, 1'b0, 32'h0);
        next_cycle();
        mem_drive(1'b1, 1'b0, 32'h0);
        settle();
        check_eq("t3_f2_addr", mem_bus.addr, 32'h0000_0104);
        check_eq("t3_f2_addr_ok", 32'(inst_bus.addr_ok), 1);
        next_cycle();
        inst_drive(1'b1, 32'h0000_0108);
        mem_drive(1'b0, 1'b0, 32'h0);
        settle();
        check_eq("t3_full_a_mem_req", 32'(mem_bus.req), 0);
        next_cycle();
        settle();
        check_eq("t3_full_b_mem_req", 32'(mem_bus.req), 0);
        next_cycle();
        mem_drive(1'b0, 1'b1, 32'h0000_0001);
        settle();
        check_eq("t3_pop_mem_req", 32'(mem_bus.req), 0);
        check_eq("t3_r1_inst_ok", 32'(inst_bus.data_ok), 1);
        check_eq("t3_r1_rdata", inst_bus.rdata, 32'h0000_0001);
        next_cycle();
        mem_drive(1'b0, 1'b0, 32'h0);
        settle();
        check_eq("t3_after_pop_mem_req", 32'(mem_bus.req), 0);
        next_cycle();
        mem_drive(1'b1, 1'b0, 32'h0);
        settle();
        check_eq("t3_f3_mem_req", 32'(mem_bus.req), 1);
        check_eq("t3_f3_addr", mem_bus.addr, 32'h0000_0108);
        check_eq("t3_f3_addr_ok", 32'(inst_bus.addr_ok), 1);
        next_cycle();
        inst_drive(1'b0, 32'h0);
        mem_drive(1'b0, 1'b1, 32'h0000_0002);
        settle();
        check_eq("t3_r2_inst_ok", 32'(inst_bus.data_ok), 1);
        next_cycle();
        mem_drive(1'b0, 1'b1, 32'h0000_0003);
        settle();
        check_eq("t3_r3_inst_ok", 32'(inst_bus.data_ok), 1);
        check_eq("t3_r3_rdata", inst_bus.rdata, 32'h0000_0003);
        next_cycle();
        mem_drive(1'b0, 1'b0, 32'h0);

        // Ordering, and no preemption of a locked inst grant.
        inst_drive(1'b1, 32'h0000_0400);
        next_cycle();
        data_drive(1'b1, 1'b0, SZ_BYTE, 32'h0000_0500, 4'h0, 32'h0);
        settle();
        check_eq("t4_lock_mem_addr", mem_bus.addr, 32'h0000_0400);
        check_eq("t4_lock_data_addr_ok", 32'(data_bus.addr_ok), 0);
        next_cycle();
        mem_drive(1'b1, 1'b0, 32'h0);
        settle();
        check_eq("t4_i_addr_ok", 32'(inst_bus.addr_ok), 1);
        check_eq("t4_i_data_addr_ok", 32'(data_bus.addr_ok), 0);
        next_cycle();
        inst_drive(1'b0, 32'h0);
        mem_drive(1'b0, 1'b0, 32'h0);
        next_cycle();
        mem_drive(1'b1, 1'b0, 32'h0);
        settle();
        check_eq("t4_d_mem_addr", mem_bus.addr, 32'h0000_0500);
        check_eq("t4_d_mem_size", 32'(mem_bus.size), 32'(SZ_BYTE));
        check_eq("t4_d_addr_ok", 32'(data_bus.addr_ok), 1);
        next_cycle();
        data_drive(1'b0, 1'b0, SZ_WORD, 32'h0, 4'h0, 32'h0);
        mem_drive(1'b0, 1'b1, 32'h0000_0011);
        settle();
        check_eq("t4_r1_inst_ok", 32'(inst_bus.data_ok), 1);
        check_eq("t4_r1_data_ok", 32'(data_bus.data_ok), 0);
        check_eq("t4_r1_rdata", inst_bus.rdata, 32'h0000_0011);
        next_cycle();
        mem_drive(1'b0, 1'b1, 32'h0000_0022);
        settle();
        check_eq("t4_r2_data_ok", 32'(data_bus.data_ok), 1);
        check_eq("t4_r2_inst_ok", 32'(inst_bus.data_ok), 0);
        check_eq("t4_r2_rdata", data_bus.rdata, 32'h0000_0022);
        next_cycle();
        mem_drive(1'b0, 1'b0, 32'h0);

        // Push and pop in the same cycle with one outstanding.
        inst_drive(1'b1, 32'h0000_0600);
        next_cycle();
        mem_drive(1'b1, 1'b0, 32'h0);
        next_cycle();
        inst_drive(1'b0, 32'h0);
        data_drive(1'b1, 1'b0, SZ_WORD, 32'h0000_0700, 4'h0, 32'h0);
        mem_drive(1'b0, 1'b0, 32'h0);
        next_cycle();
        mem_drive(1'b1, 1'b1, 32'h0000_0033);
        settle();
        check_eq("t5_pp_data_addr_ok", 32'(data_bus.addr_ok), 1);
        check_eq("t5_pp_inst_data_ok", 32'(inst_bus.data_ok), 1);
        check_eq("t5_pp_data_data_ok", 32'(data_bus.data_ok), 0);
        next_cycle();
        data_drive(1'b0, 1'b0, SZ_WORD, 32'h0, 4'h0, 32'h0);
        mem_drive(1'b0, 1'b1, 32'h0000_0044);
        settle();
        check_eq("t5_next_data_ok", 32'(data_bus.data_ok), 1);
        check_eq("t5_next_inst_ok", 32'(inst_bus.data_ok), 0);
        check_eq("t5_next_rdata", data_bus.rdata, 32'h0000_0044);
        next_cycle();
        settle();
        check_quiet("t5_drained");
        next_cycle();
        mem_drive(1'b0, 1'b0, 32'h0);

        // Reset with two outstanding, then a stray response.
        inst_drive(1'b1, 32'h0000_0800);
        next_cycle();
        mem_drive(1'b1, 1'b0, 32'h0);
        next_cycle();
        mem_drive(1'b0, 1'b0, 32'h0);
        next_cycle();
        mem_drive(1'b1, 1'b0, 32'h0);
        settle();
        check_eq("t6_f2_addr_ok", 32'(inst_bus.addr_ok), 1);
        next_cycle();
        inst_drive(1'b0, 32'h0);
        mem_drive(1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        settle();
        check_eq("t6_rst_mem_req", 32'(mem_bus.req), 0);
        next_cycle();
        reset = 1'b0;
        mem_drive(1'b0, 1'b1, 32'h0000_0055);
        settle();
        check_quiet("t6_stray");
        next_cycle();
        mem_drive(1'b0, 1'b0, 32'h0);
        data_drive(1'b1, 1'b0, SZ_WORD, 32'h0000_0900, 4'h0, 32'h0);
        settle();
        check_eq("t6_idle_mem_req", 32'(mem_bus.req), 0);
        next_cycle();
        mem_drive(1'b1, 1'b0, 32'h0);
        settle();
        check_eq("t6_d_mem_addr", mem_bus.addr, 32'h0000_0900);
        check_eq("t6_d_addr_ok", 32'(data_bus.addr_ok), 1);
        next_cycle();
        data_drive(1'b0, 1'b0, SZ_WORD, 32'h0, 4'h0, 32'h0);
        mem_drive(1'b0, 1'b1, 32'h0000_0066);
        settle();
        check_eq("t6_d_data_ok", 32'(data_bus.data_ok), 1);
        check_eq("t6_d_rdata", data_bus.rdata, 32'h0000_0066);
        check_eq("t6_d_inst_ok", 32'(inst_bus.data_ok), 0);
        next_cycle();
        mem_drive(1'b0, 1'b0, 32'h0);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
